// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants, fetch state encodings and queue entry type
package cpu_pkg;

   localparam int ADDR_W  = 8;
   localparam int INSTR_W = 16;

   localparam logic [INSTR_W-1:0] HALT_INSTR = 16'h0000;

   // instruction field positions: opcode in the top nibble, op2 below it
   localparam int OPCODE_MSB = 15;
   localparam int OPCODE_LSB = 12;
   localparam int OP2_MSB    = 11;
   localparam int OP2_LSB    = 8;

   localparam logic [1:0] FETCH_RUN   = 2'd0;
   localparam logic [1:0] FETCH_DRAIN = 2'd1;
   localparam logic [1:0] FETCH_HALT  = 2'd2;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous prefetch queue with flush
module fetch_fifo #(
   parameter int W     = 24,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [W-1:0]               push_data,
   input  logic                       pop,
   input  logic                       flush,
   output logic [W-1:0]               head,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   assign head = mem[rd_ptr];

   // pointer and occupancy update; flush discards everything, including a same-cycle push
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   // storage write, no reset needed because count gates visibility
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with prefetch queue, redirect and halt
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int                DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
   input  logic                clk,
   input  logic                rst,
   output logic                imem_req,
   output logic [ADDR_W-1:0]   imem_addr,
   input  logic [INSTR_W-1:0]  imem_rdata,
   output logic [INSTR_W-1:0]  instr,
   output logic [ADDR_W-1:0]   instr_pc,
   output logic                instr_valid,
   input  logic                instr_ready,
   input  logic                redirect,
   input  logic [ADDR_W-1:0]   redirect_pc,
   output logic                halted
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [1:0]        state;
   logic [ADDR_W-1:0] fetch_pc;
   logic              inflight;
   logic [ADDR_W-1:0] inflight_pc;

   logic [CW-1:0]     count;
   logic [CW:0]       occ_after;
   fetch_entry_t      fifo_head;
   fetch_entry_t      resp_entry;
   fetch_entry_t      head;
   logic              fifo_nonempty;
   logic              xfer;
   logic              flush;
   logic              fifo_push;
   logic              fifo_pop;
   logic              halt_seen;
   logic              room;

   // the returning word bypasses an empty queue so a fresh fetch is visible the cycle it lands
   assign resp_entry    = '{pc: inflight_pc, instr: imem_rdata};
   assign fifo_nonempty = (count != '0);
   assign head          = fifo_nonempty ? fifo_head : resp_entry;

   assign instr_valid = (fifo_nonempty || inflight) && (state != FETCH_HALT);
   assign instr       = instr_valid ? head.instr : '0;
   assign instr_pc    = instr_valid ? head.pc    : '0;
   assign halted      = (state == FETCH_HALT);

   assign xfer      = instr_valid && instr_ready;
   assign flush     = redirect && (state != FETCH_HALT);
   assign fifo_pop  = xfer && fifo_nonempty;
   assign fifo_push = inflight && !(xfer && !fifo_nonempty);
   assign halt_seen = inflight && (imem_rdata == HALT_INSTR);

   // occupancy left after this cycle; a request reserves the slot its response will need
   assign occ_after = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(xfer);
   assign room      = occ_after < (CW+1)'(DEPTH);

   // the halt word arriving this cycle must not be followed by another request
   assign imem_req  = !rst && (state == FETCH_RUN) && !redirect && room && !halt_seen;
   assign imem_addr = fetch_pc;

   fetch_fifo #(
      .W     ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (resp_entry),
      .pop       (fifo_pop),
      .flush     (flush),
      .head      (fifo_head),
      .count     (count)
   );

   // program counter, in-flight tracking and run/drain/halt sequencing
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= FETCH_RUN;
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else begin
         inflight <= imem_req;
         if (imem_req) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + ADDR_W'(1);
         end
         if (xfer && head.instr == HALT_INSTR) begin
            state <= FETCH_HALT;
         end else if (flush) begin
            state    <= FETCH_RUN;
            fetch_pc <= redirect_pc;
         end else if (halt_seen && state == FETCH_RUN) begin
            state <= FETCH_DRAIN;
         end
      end
   end

endmodule
